fir_serial_mac: RTL and testbench

Parametrised, time-multiplexed FIR filter: one multiply-accumulate per clock over N_TAPS taps, with runtime-writable coefficients.
Successor to the fixed-coefficient firfilter; keeps the clk/data/data_ready input contract.
Adds an output valid strobe, a busy indication, overrun detection and scaled, width-controlled output.
Sits between a sample source pulsing data_ready and downstream consumers of filtered samples.

---
 rtl/fir_pkg.sv | 22 ++
 rtl/fir_out_size.sv | 40 ++++
 rtl/fir_serial_mac.sv | 92 +++++++++
 tb/tb_fir_serial_mac.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared types and elaboration-time helpers for the serial-MAC FIR filter.
package fir_pkg;

    typedef logic [1:0] fir_state_t;

    localparam fir_state_t IDLE = 2'd0;
    localparam fir_state_t MAC  = 2'd1;
    localparam fir_state_t DONE = 2'd2;

    function automatic int fir_clog2(input int n);
        int r;
        r = 0;
        for (int v = 1; v < n; v = v * 2) r++;
        return r;
    endfunction

    // Wide enough that summing n full-precision products can never overflow.
    function automatic int fir_acc_w(input int data_size, input int coef_size, input int n_taps);
        return data_size + coef_size + fir_clog2(n_taps);
    endfunction

endpackage

// File: rtl/fir_out_size.sv
// Arithmetic right shift of the accumulator, then output sizing.
// FIR_SAT_EN defined: clamp to the OUT_SIZE signed range; undefined: two's-complement wrap.
module fir_out_size import fir_pkg::*; #(
    parameter int ACC_W    = 20,
    parameter int OUT_SIZE = 9,
    parameter int SHIFT    = 0
) (
    input  logic signed [ACC_W-1:0]    acc,
    output logic signed [OUT_SIZE-1:0] out_data
);

    logic signed [ACC_W-1:0] shifted;

    assign shifted = acc >>> SHIFT;

    generate
        if (OUT_SIZE >= ACC_W) begin : g_extend
            assign out_data = OUT_SIZE'(shifted);
        end else begin : g_narrow
`ifdef FIR_SAT_EN
            logic fits;
            // Fits when every bit above the output sign bit repeats the sign.
            assign fits = (shifted[ACC_W-1:OUT_SIZE-1] == {(ACC_W-OUT_SIZE+1){shifted[ACC_W-1]}});

            always_comb begin
                out_data = shifted[OUT_SIZE-1:0];
                if (!fits) begin
                    if (shifted[ACC_W-1]) out_data = {1'b1, {(OUT_SIZE-1){1'b0}}};
                    else                  out_data = {1'b0, {(OUT_SIZE-1){1'b1}}};
                end
            end
`else
            logic unused_high;
            assign unused_high = ^shifted[ACC_W-1:OUT_SIZE];
            assign out_data    = shifted[OUT_SIZE-1:0];
`endif
        end
    endgenerate

endmodule

// File: rtl/fir_serial_mac.sv
// Time-multiplexed FIR: one multiply-accumulate per clock, runtime-writable taps.
// Output sizing mode selected by FIR_SAT_EN (see fir_out_size).
module fir_serial_mac import fir_pkg::*; #(
    parameter int DATA_SIZE = 9,
    parameter int COEF_SIZE = 9,
    parameter int N_TAPS    = 3,
    parameter int OUT_SIZE  = 9,
    parameter int SHIFT     = 0
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic signed [DATA_SIZE-1:0]       data,
    input  logic                              data_ready,
    input  logic                              coef_we,
    input  logic [fir_clog2(N_TAPS)-1:0]      coef_addr,
    input  logic signed [COEF_SIZE-1:0]       coef_data,
    output logic                              busy,
    output logic signed [OUT_SIZE-1:0]        out_data,
    output logic                              out_valid,
    output logic                              overrun
);

    localparam int AW    = fir_clog2(N_TAPS);
    localparam int ACC_W = fir_acc_w(DATA_SIZE, COEF_SIZE, N_TAPS);
    localparam int PW    = DATA_SIZE + COEF_SIZE;

    logic signed [DATA_SIZE-1:0] x [N_TAPS];
    logic signed [COEF_SIZE-1:0] h [N_TAPS];
    logic signed [ACC_W-1:0]     acc;
    logic signed [PW-1:0]        prod;
    logic signed [OUT_SIZE-1:0]  sized;
    logic [AW-1:0]               idx;
    fir_state_t                  state;

    assign prod = x[idx] * h[idx];

    fir_out_size #(
        .ACC_W   (ACC_W),
        .OUT_SIZE(OUT_SIZE),
        .SHIFT   (SHIFT)
    ) u_out_size (
        .acc     (acc),
        .out_data(sized)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < N_TAPS; k++) begin
                x[k] <= '0;
                h[k] <= '0;
            end
            h[0]      <= COEF_SIZE'(1);
            acc       <= '0;
            idx       <= '0;
            state     <= IDLE;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            overrun   <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    // Taps only change here, so a computation never sees a mixed set.
                    if (coef_we && int'(coef_addr) < N_TAPS) h[coef_addr] <= coef_data;
                    if (data_ready) begin
                        for (int k = N_TAPS - 1; k > 0; k--) x[k] <= x[k-1];
                        x[0]  <= data;
                        acc   <= '0;
                        idx   <= '0;
                        busy  <= 1'b1;
                        state <= MAC;
                    end
                end
                MAC: begin
                    acc <= acc + ACC_W'(prod);
                    idx <= idx + 1'b1;
                    if (idx == AW'(N_TAPS - 1)) state <= DONE;
                end
                DONE: begin
                    out_data  <= sized;
                    out_valid <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
            if (data_ready && state != IDLE) overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fir_serial_mac.sv
// Randomised self-checking bench for fir_serial_mac against a sum-of-products reference.
module tb_fir_serial_mac;

    localparam int DS = 9;
    localparam int CS = 9;
    localparam int NT = 3;
    localparam int OS = 9;
    localparam int SH = 0;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic signed [DS-1:0] data = '0;
    logic                 data_ready = 1'b0;
    logic                 coef_we = 1'b0;
    logic [1:0]           coef_addr = '0;
    logic signed [CS-1:0] coef_data = '0;
    logic                 busy, out_valid, overrun;
    logic signed [OS-1:0] out_data;

    int total = 0;
    int bad   = 0;

    // Reference state: hist[k] is the sample accepted k samples ago.
    int hist [NT];
    int coef [NT];

    always #5 clk = ~clk;

    fir_serial_mac #(
        .DATA_SIZE(DS), .COEF_SIZE(CS), .N_TAPS(NT), .OUT_SIZE(OS), .SHIFT(SH)
    ) dut (
        .clk(clk), .rst(rst), .data(data), .data_ready(data_ready),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .busy(busy), .out_data(out_data), .out_valid(out_valid), .overrun(overrun)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void model_reset();
        for (int k = 0; k < NT; k++) begin
            hist[k] = 0;
            coef[k] = 0;
        end
        coef[0] = 1;
    endfunction

    function automatic void model_accept(input int d);
        for (int k = NT - 1; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = d;
    endfunction

    function automatic logic [OS-1:0] model_out();
        longint s;
        s = 0;
        for (int k = 0; k < NT; k++) s += longint'(coef[k]) * longint'(hist[k]);
        s = s >>> SH;
`ifdef FIR_SAT_EN
        if (s > longint'((1 << (OS-1)) - 1)) s = longint'((1 << (OS-1)) - 1);
        if (s < -longint'(1 << (OS-1)))      s = -longint'(1 << (OS-1));
`endif
        return s[OS-1:0];
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
    endtask

    task automatic write_coef(input logic [1:0] a, input logic signed [CS-1:0] v);
        coef_we = 1'b1; coef_addr = a; coef_data = v;
        tick();
        coef_we = 1'b0;
        if (int'(a) < NT) coef[a] = int'(v);
    endtask

    // Accepts one sample (optionally with a same-cycle tap write and a dropped
    // strobe drop_at cycles later) and waits for the result.
    task automatic send_sample(input logic signed [DS-1:0] d, input int drop_at,
                               input logic cw, input logic [1:0] ca, input logic signed [CS-1:0] cv,
                               output logic [OS-1:0] got, output int lat, output int bcnt);
        data = d; data_ready = 1'b1;
        coef_we = cw; coef_addr = ca; coef_data = cv;
        tick();
        data_ready = 1'b0; coef_we = 1'b0;
        if (cw && int'(ca) < NT) coef[ca] = int'(cv);
        model_accept(int'(d));
        lat = -1; bcnt = 0; got = 'x;
        for (int n = 0; n < 20 && lat < 0; n++) begin
            if (busy) bcnt++;
            if (out_valid) begin
                lat = n;
                got = out_data;
            end else begin
                if (n == drop_at) begin
                    data = DS'($urandom);
                    data_ready = 1'b1;
                end
                tick();
                data_ready = 1'b0;
            end
        end
        tick();
    endtask

    task automatic wait_valid(output logic [OS-1:0] got, output int lat);
        lat = -1; got = 'x;
        for (int n = 0; n < 20 && lat < 0; n++) begin
            if (out_valid) begin
                lat = n;
                got = out_data;
            end else tick();
        end
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        model_reset();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        total++; if (out_data !== '0) begin bad++; $display("FAIL reset_out: got %h want 000", out_data); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    endtask

    task automatic test_identity();
        logic [OS-1:0] got;
        int lat, bcnt;
        do_reset();
        send_sample(9'h010, -1, 1'b0, 2'd0, 9'sd0, got, lat, bcnt);
        total++; if (lat !== 4) begin bad++; $display("FAIL ident_latency: got %0d want 4", lat); end
        total++; if (got !== 9'h010) begin bad++; $display("FAIL ident_out: got %h want 010", got); end
        total++; if (bcnt !== 4) begin bad++; $display("FAIL ident_busy_cycles: got %0d want 4", bcnt); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ident_pulse: got %b want 0", out_valid); end
        total++; if (out_data !== 9'h010) begin bad++; $display("FAIL ident_hold: got %h want 010", out_data); end
    endtask

    task automatic test_coefs();
        logic [OS-1:0] got;
        logic [OS-1:0] want [3];
        logic [DS-1:0] smp [3];
        int lat, bcnt;
        want[0] = 9'h010; want[1] = 9'h035; want[2] = 9'h05A;
        smp[0]  = 9'h010; smp[1]  = 9'h015; smp[2]  = 9'h020;
        do_reset();
        write_coef(2'd0, 9'sd1);
        write_coef(2'd1, 9'sd2);
        write_coef(2'd2, 9'sd1);
        for (int i = 0; i < 3; i++) begin
            send_sample(smp[i], -1, 1'b0, 2'd0, 9'sd0, got, lat, bcnt);
            total++; if (got !== want[i]) begin bad++; $display("FAIL coefs_out%0d: got %h want %h", i, got, want[i]); end
            repeat (4) tick();
        end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL coefs_overrun: got %b want 0", overrun); end
    endtask

    task automatic test_overrun();
        logic [OS-1:0] got, want;
        int lat, bcnt;
        send_sample(9'h030, 2, 1'b0, 2'd0, 9'sd0, got, lat, bcnt);
        want = model_out();
        total++; if (got !== want) begin bad++; $display("FAIL overrun_out: got %h want %h", got, want); end
        total++; if (lat !== 4) begin bad++; $display("FAIL overrun_latency: got %0d want 4", lat); end
        total++; if (overrun !== 1'b1) begin bad++; $display("FAIL overrun_set: got %b want 1", overrun); end
        send_sample(9'h011, -1, 1'b0, 2'd0, 9'sd0, got, lat, bcnt);
        want = model_out();
        total++; if (got !== want) begin bad++; $display("FAIL overrun_next: got %h want %h", got, want); end
        total++; if (overrun !== 1'b1) begin bad++; $display("FAIL overrun_sticky: got %b want 1", overrun); end
    endtask

    task automatic test_saturation();
        logic [OS-1:0] got, want;
        int lat, bcnt;
        do_reset();
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL sat_overrun_clr: got %b want 0", overrun); end
        for (int k = 0; k < NT; k++) write_coef(2'(k), 9'sd127);
        for (int i = 0; i < 3; i++) begin
            send_sample(9'h0FF, -1, 1'b0, 2'd0, 9'sd0, got, lat, bcnt);
            want = model_out();
            total++; if (got !== want) begin bad++; $display("FAIL sat_model%0d: got %h want %h", i, got, want); end
        end
`ifdef FIR_SAT_EN
        want = 9'h0FF;
`else
        want = 9'h183;
`endif
        total++; if (got !== want) begin bad++; $display("FAIL sat_third: got %h want %h", got, want); end
    endtask

    task automatic test_reset_mid();
        logic [OS-1:0] got;
        int lat, bcnt, pulses;
        for (int k = 0; k < NT; k++) write_coef(2'(k), 9'sd3);
        data = 9'h040; data_ready = 1'b1;
        tick();
        data_ready = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy: got %b want 0", busy); end
        pulses = 0;
        for (int n = 0; n < 8; n++) begin
            if (out_valid) pulses++;
            tick();
        end
        total++; if (pulses !== 0) begin bad++; $display("FAIL midrst_no_valid: got %0d pulses want 0", pulses); end
        send_sample(9'h020, -1, 1'b0, 2'd0, 9'sd0, got, lat, bcnt);
        total++; if (got !== 9'h020) begin bad++; $display("FAIL midrst_identity: got %h want 020", got); end
    endtask

    task automatic test_coef_busy();
        logic [OS-1:0] got, want;
        int lat, bcnt;
        data = 9'h007; data_ready = 1'b1;
        tick();
        data_ready = 1'b0;
        model_accept(7);
        coef_we = 1'b1; coef_addr = 2'd0; coef_data = 9'sd5;
        tick();
        coef_we = 1'b0;
        wait_valid(got, lat);
        want = model_out();
        total++; if (lat < 0) begin bad++; $display("FAIL cbusy_timeout: got %0d want >=0", lat); end
        total++; if (got !== want) begin bad++; $display("FAIL cbusy_inflight: got %h want %h", got, want); end
        send_sample(9'h009, -1, 1'b0, 2'd0, 9'sd0, got, lat, bcnt);
        want = model_out();
        total++; if (got !== want) begin bad++; $display("FAIL cbusy_next: got %h want %h", got, want); end
    endtask

    task automatic test_random();
        logic [OS-1:0] got, want;
        int lat, bcnt;
        logic cw;
        do_reset();
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 2) == 0)
                write_coef(2'($urandom_range(0, 3)), CS'($urandom));
            cw = ($urandom_range(0, 3) == 0);
            send_sample(DS'($urandom), -1, cw, 2'($urandom_range(0, 3)), CS'($urandom), got, lat, bcnt);
            want = model_out();
            total++; if (got !== want) begin bad++; $display("FAIL rand_out%0d: got %h want %h", i, got, want); end
            total++; if (lat !== 4) begin bad++; $display("FAIL rand_latency%0d: got %0d want 4", i, lat); end
        end
    endtask

    initial begin
        test_reset();
        test_identity();
        test_coefs();
        test_overrun();
        test_saturation();
        test_reset_mid();
        test_coef_busy();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
